// File: rtl/io_cfg_ctrl.sv
// Configuration controller for the bidirectional IO cell array: one word per pad,
// req/gnt access port and an enforced high-Z dead time on every input->output switch.
module io_cfg_ctrl #(
  parameter int unsigned NUM_PADS    = 16,
  parameter int unsigned CONF_WIDTH  = 3,
  parameter int unsigned TURN_CYCLES = 4,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_PADS)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cfg_req,
  input  logic                           cfg_we,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr,
  input  logic [CONF_WIDTH-1:0]          cfg_wdata,
  output logic                           cfg_gnt,
  output logic                           cfg_done,
  output logic [CONF_WIDTH-1:0]          cfg_rdata,
  output logic                           cfg_err,
  output logic                           busy,
  output logic [NUM_PADS*CONF_WIDTH-1:0] io_cell_cfg,
  input  logic [NUM_PADS-1:0]            core_out,
  output logic [NUM_PADS-1:0]            pad_from_core
);

  localparam int unsigned CntWidth = $clog2(TURN_CYCLES + 1);
  localparam int unsigned CfgBits  = NUM_PADS * CONF_WIDTH;
  localparam logic [CONF_WIDTH-1:0] WordRst = CONF_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StTurn, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CfgBits-1:0]      cfg_q, cfg_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CONF_WIDTH-1:0]   data_q, data_d;
  logic [CONF_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [CONF_WIDTH-1:0]   cur_word;
  logic [NUM_PADS-1:0]     dir;
  logic                    addr_ok;
  logic                    in_to_out;

  function automatic logic [CfgBits-1:0] put_word(input logic [CfgBits-1:0]    vec,
                                                   input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [CONF_WIDTH-1:0] w);
    logic [CfgBits-1:0] r;
    r = vec;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      if (32'(a) == i) r[i*CONF_WIDTH +: CONF_WIDTH] = w;
    end
    return r;
  endfunction

  assign cfg_gnt = cfg_req & (state_q == StIdle);
  assign addr_ok = 32'(cfg_addr) < NUM_PADS;

  always_comb begin
    cur_word = '0;
    dir      = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      dir[i] = cfg_q[i*CONF_WIDTH];
      if (32'(cfg_addr) == i) cur_word = cfg_q[i*CONF_WIDTH +: CONF_WIDTH];
    end
  end

  // Only a 1->0 flip of the direction bit needs the dead time.
  assign in_to_out     = cur_word[0] & ~cfg_wdata[0];
  assign pad_from_core = core_out & ~dir;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_gnt) begin
          done_d = 1'b1;
          err_d  = ~addr_ok;
          if (!cfg_we) begin
            rdata_d = cur_word;
          end else if (addr_ok) begin
            if (in_to_out) begin
              done_d  = 1'b0;
              addr_d  = cfg_addr;
              data_d  = cfg_wdata;
              cnt_d   = CntWidth'(TURN_CYCLES);
              state_d = StTurn;
            end else begin
              cfg_d = put_word(cfg_q, cfg_addr, cfg_wdata);
            end
          end
        end
      end
      StTurn: begin
        if (cnt_q == CntWidth'(1)) begin
          cfg_d   = put_word(cfg_q, addr_q, data_q);
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StTurn);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cfg_q   <= {NUM_PADS{WordRst}};
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign cfg_rdata   = rdata_q;
  assign busy        = busy_q;
  assign io_cell_cfg = cfg_q;

endmodule

// File: tb/tb_io_cfg_ctrl.sv
// Bench for io_cfg_ctrl: transaction-timeline reference model, directed scenarios,
// then randomized traffic, all compared every cycle.
module tb_io_cfg_ctrl;
  localparam int NP = 16;
  localparam int CW = 3;
  localparam int TC = 4;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_req = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [CW-1:0]     cfg_wdata = '0;
  logic              cfg_gnt;
  logic              cfg_done;
  logic [CW-1:0]     cfg_rdata;
  logic              cfg_err;
  logic              busy;
  logic [NP*CW-1:0]  io_cell_cfg;
  logic [NP-1:0]     core_out = '0;
  logic [NP-1:0]     pad_from_core;

  io_cfg_ctrl #(
    .NUM_PADS   (NP),
    .CONF_WIDTH (CW),
    .TURN_CYCLES(TC),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_req      (cfg_req),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_gnt      (cfg_gnt),
    .cfg_done     (cfg_done),
    .cfg_rdata    (cfg_rdata),
    .cfg_err      (cfg_err),
    .busy         (busy),
    .io_cell_cfg  (io_cell_cfg),
    .core_out     (core_out),
    .pad_from_core(pad_from_core)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int busy_seen = 0;
  int done_seen = 0;

  // Model: words plus a timeline (cycle numbers) of when things become visible.
  logic [CW-1:0] m_w [NP];
  int            cyc;
  int            m_free;
  int            done_at;
  logic          e_err;
  logic          e_rd;
  logic [CW-1:0] e_rdata;
  logic          p_valid;
  int            p_addr;
  logic [CW-1:0] p_data;
  int            p_apply;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_w[i] = CW'(1);
    cyc     = 0;
    m_free  = 0;
    done_at = -1;
    e_err   = 1'b0;
    e_rd    = 1'b0;
    e_rdata = '0;
    p_valid = 1'b0;
    p_addr  = 0;
    p_data  = '0;
    p_apply = 0;
  endtask

  function automatic logic [NP*CW-1:0] exp_cfg();
    logic [NP*CW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*CW +: CW] = m_w[i];
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_dir();
    logic [NP-1:0] d;
    for (int i = 0; i < NP; i++) d[i] = m_w[i][0];
    return d;
  endfunction

  task automatic step(input logic req, input logic we, input logic [AW-1:0] a,
                      input logic [CW-1:0] wd, input logic [NP-1:0] co, output logic g);
    int ai;
    @(negedge clk);
    cfg_req   = req;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = wd;
    core_out  = co;
    #1;
    g = req && (cyc >= m_free);
    chk("gnt", cfg_gnt, g);
    chk("cell_cfg", io_cell_cfg, exp_cfg());
    chk("busy", busy, p_valid);
    chk("done", cfg_done, cyc == done_at);
    if (cyc == done_at) begin
      chk("err", cfg_err, e_err);
      if (e_rd) chk("rdata", cfg_rdata, e_rdata);
    end
    chk("pad_from_core", pad_from_core, co & ~exp_dir());
    busy_seen += int'(busy);
    done_seen += int'(cfg_done);
    @(posedge clk);
    ai = int'(a);
    if (g) begin
      e_rd = ~we;
      if (!we) begin
        done_at = cyc + 1;
        e_err   = (ai >= NP);
        e_rdata = (ai >= NP) ? '0 : m_w[ai];
        m_free  = cyc + 1;
      end else if (ai >= NP) begin
        done_at = cyc + 1;
        e_err   = 1'b1;
        m_free  = cyc + 1;
      end else if (m_w[ai][0] && !wd[0]) begin
        p_valid = 1'b1;
        p_addr  = ai;
        p_data  = wd;
        p_apply = cyc + TC + 1;
        done_at = cyc + TC + 1;
        e_err   = 1'b0;
        m_free  = cyc + TC + 2;
      end else begin
        m_w[ai] = wd;
        done_at = cyc + 1;
        e_err   = 1'b0;
        m_free  = cyc + 1;
      end
    end
    cyc++;
    if (p_valid && cyc == p_apply) begin
      m_w[p_addr] = p_data;
      p_valid     = 1'b0;
    end
  endtask

  initial begin
    logic          g;
    int            denied;
    logic [NP*CW-1:0] rst_cfg;
    logic [NP-1:0] ones;
    ones = '1;
    for (int i = 0; i < NP; i++) rst_cfg[i*CW +: CW] = 3'b001;

    model_reset();
    core_out = ones;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cell_cfg", io_cell_cfg, rst_cfg);
    chk("rst_pad_from_core", pad_from_core, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cfg_done, 0);
    rstn = 1'b1;

    // Input->output turnaround on pad 3.
    busy_seen = 0;
    done_seen = 0;
    step(1'b1, 1'b1, 5'd3, 3'b000, ones, g);
    repeat (6) step(1'b0, 1'b0, 5'd0, 3'b000, ones, g);
    chk("turn_busy_len", busy_seen, TC);
    chk("turn_done_count", done_seen, 1);
    chk("turn_word3", io_cell_cfg[11:9], 3'b000);
    chk("turn_pad3_driven", pad_from_core[3], 1'b1);

    // Output->input is immediate.
    busy_seen = 0;
    step(1'b1, 1'b1, 5'd3, 3'b001, ones, g);
    #1;
    chk("o2i_pad3", pad_from_core[3], 1'b0);
    chk("o2i_done", cfg_done, 1'b1);
    step(1'b0, 1'b0, 5'd0, 3'b000, ones, g);
    chk("o2i_no_busy", busy_seen, 0);

    // Reads, in and out of range; out-of-range write.
    step(1'b1, 1'b0, 5'd3, 3'b000, ones, g);
    #1;
    chk("rd3_rdata", cfg_rdata, 3'b001);
    chk("rd3_err", cfg_err, 1'b0);
    step(1'b1, 1'b0, 5'd20, 3'b000, ones, g);
    #1;
    chk("rd20_err", cfg_err, 1'b1);
    chk("rd20_rdata", cfg_rdata, 3'b000);
    step(1'b1, 1'b1, 5'd20, 3'b000, ones, g);
    #1;
    chk("wr20_err", cfg_err, 1'b1);
    chk("wr20_cells", io_cell_cfg, rst_cfg);

    // Request held through a turnaround.
    step(1'b1, 1'b1, 5'd5, 3'b000, ones, g);
    denied = 0;
    g = 1'b0;
    for (int i = 0; i < 12 && !g; i++) begin
      step(1'b1, 1'b1, 5'd5, 3'b010, ones, g);
      if (!g) denied++;
    end
    chk("hold_denied", denied, TC + 1);
    #1;
    chk("hold_word5", io_cell_cfg[17:15], 3'b010);
    step(1'b0, 1'b0, 5'd0, 3'b000, ones, g);

    // Reset in the second TURN cycle.
    step(1'b1, 1'b1, 5'd7, 3'b000, ones, g);
    step(1'b0, 1'b0, 5'd0, 3'b000, ones, g);
    @(negedge clk);
    cfg_req = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("midrst_cells", io_cell_cfg, rst_cfg);
    chk("midrst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    done_seen = 0;
    repeat (8) step(1'b0, 1'b0, 5'd0, 3'b000, ones, g);
    chk("midrst_no_done", done_seen, 0);
    step(1'b1, 1'b0, 5'd7, 3'b000, ones, g);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 9) < 6, 1'($urandom), AW'($urandom_range(0, 21)),
           CW'($urandom), NP'($urandom), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
